hs_upload_engine: RTL and testbench
===================================

Name: hs_upload_engine

Overview:
- Transmit side of the hiscore/NVRAM path: streams a region of game work RAM to the HPS over the ioctl upload channel.
- Complements the download-side capture logic, which fills RAM and DIP registers from ioctl writes.
- Sits in the emu top between hps_io (ioctl_upload/ioctl_rd/ioctl_din/ioctl_upload_req), the game core's RAM read port and the pause block.
- Freezes the CPU for the whole transfer so the saved snapshot is coherent.

Parameters:
- AW, 16: game RAM address width.
- UP_INDEX, 8'd4: ioctl_index value that identifies a hiscore upload.
- REQ_CYCLES, 4: number of cycles ioctl_upload_req is held high per request.
- TIMEOUT, 1000000: cycles to wait for the HPS to start an upload after a request.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- save_trigger  in  1  one-cycle pulse asking for an autosave upload.
- region_base  in  AW  first RAM address of the saved region; static during a transfer.
- region_len  in  16  byte count of the region; 0 means nothing is saved.
- ioctl_upload  in  1  HPS upload-in-progress level.
- ioctl_index  in  8  upload target index.
- ioctl_rd  in  1  one-cycle read strobe from the HPS.
- ioctl_addr  in  25  byte offset within the upload stream.
- ioctl_din  out  8  data returned to the HPS.
- ioctl_upload_req  out  1  upload request to hps_io.
- pause_req  out  1  CPU pause request to the pause block.
- paused  in  1  pause acknowledge; CPU is halted.
- ram_addr  out  AW  game RAM read address.
- ram_rd  out  1  read strobe; synchronous RAM, ram_dout valid the cycle after.
- ram_dout  in  8  RAM read data.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async assert, sync release) values: state=IDLE, ioctl_din=8'h00, ioctl_upload_req=0, pause_req=0, ram_rd=0, ram_addr=0, busy=0, counters=0.
- Upload match: the condition ioctl_upload=1 with ioctl_index==UP_INDEX.
- FSM states: IDLE, REQ, WAIT_UP, PAUSE, SERVE, RELEASE.
- IDLE:
  - save_trigger -> REQ.
  - Upload match rising (user-initiated upload) -> PAUSE directly.
  - Upload match and save_trigger in the same cycle -> PAUSE; the trigger is consumed.
- REQ: ioctl_upload_req=1 for exactly REQ_CYCLES cycles, then -> WAIT_UP.
- WAIT_UP:
  - Upload match -> PAUSE.
  - Timeout counter reaches TIMEOUT-1 -> IDLE; pause_req is never raised on this path.
- PAUSE:
  - pause_req=1; on paused=1 -> SERVE.
  - If ioctl_upload falls first -> RELEASE.
- SERVE: pause_req stays 1. On each ioctl_rd:
  - If ioctl_addr < region_len: ram_addr = region_base + ioctl_addr[AW-1:0], truncated to AW bits (wraps at the top of RAM). ram_rd pulses 1 cycle. ram_dout is registered into ioctl_din on the following cycle, so ioctl_din is valid 2 cycles after ioctl_rd.
  - Else: no ram_rd; ioctl_din=8'hFF, 2 cycles after ioctl_rd (same latency).
  - region_len=0: every read returns 8'hFF.
  - A new ioctl_rd while a read is pending aborts the pending read; only the newest address is returned, 2 cycles after its strobe.
  - ioctl_rd outside SERVE is ignored; ioctl_din holds its last value.
  - ioctl_upload falling -> RELEASE.
- RELEASE: pause_req=0 for one cycle, then -> IDLE.
- save_trigger outside IDLE is ignored; no queueing.
- paused dropping during SERVE: reads continue; pause_req stays asserted.
- Reset mid-transfer: pause_req drops immediately (async); the upload is abandoned.

Test Plan:
- Basic save: base=16'h8800, len=16, RAM[8800+i]=i. Pulse save_trigger -> upload_req high exactly 4 cycles. Raise upload(index 4), assert paused, rd addr 0..15 spaced 4 cycles apart -> din=0x00..0x0F, each valid 2 cycles after its rd; pause_req drops 1 cycle after upload falls.
- Out-of-range: len=4, rd addr 4 and addr 1000 -> din=8'hFF, ram_rd never asserted.
- Timeout: pulse save_trigger, never raise upload -> state IDLE after REQ_CYCLES+TIMEOUT cycles, pause_req never 1.
- Wrong index / user upload: upload with index 3 -> no response. Upload with index 4 from IDLE, no trigger -> pause_req rises next cycle; reads start only after paused=1.
- Wrap and back-to-back: base=16'hFFFE, rd addr 3 -> ram_addr=16'h0001. Two rds 1 cycle apart (addrs 0 then 2) -> only addr-2 data appears, 2 cycles after the second rd.
- Reset mid-SERVE: drop reset_n -> pause_req, ram_rd, busy all 0 the same cycle; after release, state IDLE, din=8'h00.

Source files
------------

// File: rtl/hs_upload_engine.sv
`default_nettype none
// ============================================================================
// Module   : hs_upload_engine
// Brief    : Streams a game work-RAM region to the HPS over the ioctl upload
//            channel while holding the CPU paused for a coherent snapshot.
// Revision : 1.0
// ============================================================================
module hs_upload_engine #(
    parameter int         AW         = 16,
    parameter logic [7:0] UP_INDEX   = 8'd4,
    parameter int         REQ_CYCLES = 4,
    parameter int         TIMEOUT    = 1000000
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          save_trigger,
    input  logic [AW-1:0] region_base,
    input  logic [15:0]   region_len,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_upload_req,
    output logic          pause_req,
    input  logic          paused,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_dout,
    output logic          busy
);
    localparam int c_cnt_max = (TIMEOUT > REQ_CYCLES) ? TIMEOUT : REQ_CYCLES;
    localparam int c_cw      = $clog2(c_cnt_max + 1);
    localparam logic [c_cw-1:0] c_req_last = c_cw'(REQ_CYCLES - 1);
    localparam logic [c_cw-1:0] c_to_last  = c_cw'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT_UP = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_SERVE   = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic            upload_req_q, upload_req_d;
    logic            pause_req_q, pause_req_d;
    logic [7:0]      din_q, din_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic            pend_ram_q, pend_ram_d;
    logic            pend_ff_q, pend_ff_d;
    logic            match_prev_q, match_prev_d;

    logic            w_match;
    logic            w_rd_fire;
    logic            w_in_range;
    logic            w_rd_ram;

    always_comb begin
        w_match    = ioctl_upload && (ioctl_index == UP_INDEX);
        w_rd_fire  = (state_q == ST_SERVE) && ioctl_rd;
        w_in_range = ioctl_addr < {9'd0, region_len};
        w_rd_ram   = w_rd_fire && w_in_range;

        state_d      = state_q;
        cnt_d        = cnt_q;
        upload_req_d = upload_req_q;
        pause_req_d  = pause_req_q;
        din_d        = din_q;
        ram_addr_d   = ram_addr_q;
        match_prev_d = w_match;
        pend_ram_d   = w_rd_ram;
        pend_ff_d    = w_rd_fire && !w_in_range;

        // A fresh strobe supersedes whatever read was still in flight.
        if (!w_rd_fire) begin
            if (pend_ram_q) begin
                din_d = ram_dout;
            end else if (pend_ff_q) begin
                din_d = 8'hFF;
            end
        end
        if (w_rd_ram) begin
            ram_addr_d = region_base + ioctl_addr[AW-1:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (w_match && !match_prev_q) begin
                    state_d     = ST_PAUSE;
                    pause_req_d = 1'b1;
                end else if (save_trigger) begin
                    state_d      = ST_REQ;
                    upload_req_d = 1'b1;
                    cnt_d        = '0;
                end
            end
            ST_REQ: begin
                if (cnt_q == c_req_last) begin
                    state_d      = ST_WAIT_UP;
                    upload_req_d = 1'b0;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_UP: begin
                if (w_match) begin
                    state_d     = ST_PAUSE;
                    pause_req_d = 1'b1;
                    cnt_d       = '0;
                end else if (cnt_q == c_to_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (!ioctl_upload) begin
                    state_d     = ST_RELEASE;
                    pause_req_d = 1'b0;
                end else if (paused) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!ioctl_upload) begin
                    state_d     = ST_RELEASE;
                    pause_req_d = 1'b0;
                end
            end
            ST_RELEASE: begin
                state_d     = ST_IDLE;
                pause_req_d = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                upload_req_d = 1'b0;
                pause_req_d  = 1'b0;
                cnt_d        = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            upload_req_q <= 1'b0;
            pause_req_q  <= 1'b0;
            din_q        <= 8'h00;
            ram_addr_q   <= '0;
            pend_ram_q   <= 1'b0;
            pend_ff_q    <= 1'b0;
            match_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            upload_req_q <= upload_req_d;
            pause_req_q  <= pause_req_d;
            din_q        <= din_d;
            ram_addr_q   <= ram_addr_d;
            pend_ram_q   <= pend_ram_d;
            pend_ff_q    <= pend_ff_d;
            match_prev_q <= match_prev_d;
        end
    end

    // RAM strobe is issued in the strobe cycle so the data lands two cycles out.
    assign ram_rd           = w_rd_ram;
    assign ram_addr         = ram_addr_d;
    assign ioctl_din        = din_q;
    assign ioctl_upload_req = upload_req_q;
    assign pause_req        = pause_req_q;
    assign busy             = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hs_upload_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_upload_engine
// Brief    : Scoreboard bench for hs_upload_engine upload/pause sequencing.
// Revision : 1.0
// ============================================================================
module tb_hs_upload_engine;
    localparam int AW = 16;
    localparam int RQ = 4;
    localparam int TO = 40;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          save_trigger = 1'b0;
    logic [AW-1:0] region_base = '0;
    logic [15:0]   region_len = '0;
    logic          ioctl_upload = 1'b0;
    logic [7:0]    ioctl_index = 8'd0;
    logic          ioctl_rd = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_din;
    logic          ioctl_upload_req;
    logic          pause_req;
    logic          paused = 1'b0;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [7:0]    ram_dout = 8'h00;
    logic          busy;

    hs_upload_engine #(.AW(AW), .UP_INDEX(8'd4), .REQ_CYCLES(RQ), .TIMEOUT(TO)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .save_trigger(save_trigger),
        .region_base(region_base), .region_len(region_len),
        .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_upload_req(ioctl_upload_req),
        .pause_req(pause_req), .paused(paused), .ram_addr(ram_addr), .ram_rd(ram_rd),
        .ram_dout(ram_dout), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0] data;
        int         due;
        int         addr;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    int            ram_rd_cnt = 0;
    logic [AW-1:0] last_ram_addr;
    logic          last_ram_rd;

    function automatic logic [7:0] mem_val(input logic [AW-1:0] a);
        return a[7:0];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk_sys) begin
        cyc++;
        if (ram_rd) ram_dout <= mem_val(ram_addr);
    end

    always @(negedge clk_sys) begin
        exp_t e;
        if (ram_rd) ram_rd_cnt++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check_val($sformatf("din@%0d", e.addr), {24'd0, ioctl_din}, {24'd0, e.data});
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_rd(input logic [24:0] a);
        exp_t            e;
        logic [AW-1:0]   ra;
        ra     = region_base + a[AW-1:0];
        e.data = (a < {9'd0, region_len}) ? mem_val(ra) : 8'hFF;
        e.due  = cyc + 2;
        e.addr = int'(a);
        // A strobe one cycle after the previous one cancels that read.
        if (sb.size() > 0 && sb[sb.size()-1].due == cyc + 1) sb.delete(sb.size() - 1);
        sb.push_back(e);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        #2;
        last_ram_addr = ram_addr;
        last_ram_rd   = ram_rd;
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b0;
    endtask

    task automatic start_up();
        ioctl_index  = 8'd4;
        ioctl_upload = 1'b1;
        tick();
        paused = 1'b1;
        tick();
        tick();
    endtask

    task automatic end_up();
        ioctl_upload = 1'b0;
        tick();
        tick();
        paused = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int pcnt;
        int rc0;

        repeat (3) tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_pause", pause_req, 0);
        check_val("rst_req", ioctl_upload_req, 0);
        check_val("rst_din", ioctl_din, 8'h00);
        check_val("rst_ram_rd", ram_rd, 0);
        check_val("rst_ram_addr", ram_addr, 0);
        reset_n = 1'b1;
        tick();

        // Basic autosave
        region_base = 16'h8800;
        region_len  = 16'd16;
        save_trigger = 1'b1;
        tick();
        save_trigger = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (ioctl_upload_req) cnt++;
            tick();
        end
        check_val("req_cycles", cnt, RQ);
        check_val("busy_wait", busy, 1);
        ioctl_index  = 8'd4;
        ioctl_upload = 1'b1;
        tick();
        check_val("pause_req_up", pause_req, 1);
        paused = 1'b1;
        tick();
        tick();
        rc0 = ram_rd_cnt;
        for (int i = 0; i < 16; i++) begin
            do_rd(25'(i));
            repeat (3) tick();
        end
        check_val("ram_rd_basic", ram_rd_cnt - rc0, 16);
        check_val("sb_basic", sb.size(), 0);
        ioctl_upload = 1'b0;
        check_val("pause_hold", pause_req, 1);
        tick();
        check_val("pause_drop", pause_req, 0);
        tick();
        paused = 1'b0;
        tick();
        check_val("idle_basic", busy, 0);

        // User-initiated upload, out-of-range reads
        region_base = 16'h0100;
        region_len  = 16'd4;
        ioctl_upload = 1'b1;
        tick();
        check_val("user_pause", pause_req, 1);
        check_val("user_noreq", ioctl_upload_req, 0);
        rc0 = ram_rd_cnt;
        ioctl_addr = 25'd1;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        repeat (3) tick();
        check_val("pause_rd_ram", ram_rd_cnt - rc0, 0);
        check_val("pause_rd_din", ioctl_din, 8'h0F);
        paused = 1'b1;
        tick();
        tick();
        rc0 = ram_rd_cnt;
        do_rd(25'd1);
        repeat (3) tick();
        do_rd(25'd4);
        repeat (3) tick();
        do_rd(25'd1000);
        repeat (3) tick();
        check_val("oor_ram_rd", ram_rd_cnt - rc0, 1);
        end_up();

        // Wrong index is ignored
        ioctl_index  = 8'd3;
        ioctl_upload = 1'b1;
        repeat (3) tick();
        check_val("wrong_idx_pause", pause_req, 0);
        check_val("wrong_idx_busy", busy, 0);
        ioctl_upload = 1'b0;
        tick();

        // Timeout with no upload
        save_trigger = 1'b1;
        tick();
        save_trigger = 1'b0;
        cnt  = 0;
        pcnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) cnt++;
            if (pause_req) pcnt++;
            tick();
        end
        check_val("timeout_len", cnt, RQ + TO);
        check_val("timeout_nopause", pcnt, 0);

        // Empty region
        region_base = 16'h0040;
        region_len  = 16'd0;
        start_up();
        do_rd(25'd0);
        repeat (3) tick();
        end_up();

        // Wrap and back-to-back abort
        region_base = 16'hFFFE;
        region_len  = 16'd16;
        start_up();
        do_rd(25'd3);
        check_val("wrap_addr", last_ram_addr, 16'h0001);
        check_val("wrap_rd", last_ram_rd, 1);
        repeat (3) tick();
        do_rd(25'd0);
        do_rd(25'd2);
        check_val("abort_stale", ioctl_din, 8'h01);
        repeat (3) tick();
        check_val("sb_wrap", sb.size(), 0);

        // Reset mid-SERVE
        ioctl_addr = 25'd5;
        ioctl_rd   = 1'b1;
        #2;
        check_val("pre_rst_rd", ram_rd, 1);
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_pause", pause_req, 0);
        check_val("rst_mid_ram_rd", ram_rd, 0);
        check_val("rst_mid_busy", busy, 0);
        ioctl_rd     = 1'b0;
        ioctl_upload = 1'b0;
        paused       = 1'b0;
        sb.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_val("post_rst_busy", busy, 0);
        check_val("post_rst_din", ioctl_din, 8'h00);
        check_val("post_rst_pause", pause_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
